eth_mii_tx: RTL and testbench
=============================

# eth_mii_tx

Transmit MAC stage sitting directly downstream of the APB Ethernet controller's transmit byte buffer. On a start pulse it reads `len` bytes from the buffer, then drives a complete IEEE 802.3 frame onto a 4-bit MII transmit interface:

- preamble and SFD;
- payload, zero-padded to the 60-byte minimum;
- CRC-32 FCS;
- enforced inter-frame gap.

It replaces the simulation-only DPI send path with synthesizable logic, in a single clock domain paced by a nibble strobe.

## Interface
Parameters:
- MTU, 1536, buffer depth in bytes; `len` is clamped to this value.
- ADDR_W, 11, buffer address width; must satisfy 2**ADDR_W >= MTU.
- IFG_NIB, 24, inter-frame gap length in nibble strobes (12 byte times).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low. Reset rst_n, asynchronous, active-low; clock clk.
- start  in  1  one-cycle pulse requesting transmission; sampled only in IDLE.
- len  in  16  frame length in bytes excluding FCS; sampled on the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of the IFG.
- buf_addr  out  ADDR_W  byte address into the transmit buffer.
- buf_data  in  8  buffer read data; valid 1 clk after buf_addr.
- nib_stb  in  1  one-cycle nibble enable derived from tx_clk; consecutive strobes are at least 3 clk apart.
- mii_txd  out  4  transmit nibble.
- mii_tx_en  out  1  transmit enable.

## Operation
State machine: IDLE -> PRE -> DATA -> PAD -> FCS -> IFG -> IDLE.

- **IDLE**
  - start=1 latches `len_q = min(len, MTU)`, sets buf_addr=0, clears the nibble counter, and loads crc=32'hFFFFFFFF.
  - start while not in IDLE is ignored; no queueing.
- **PRE**: 16 nibbles: 15 × 4'h5, then 4'hD (the SFD byte 0xD5, low nibble first).
  - If len_q=0, go to PAD instead of DATA.
- **DATA**
  - Each byte is sent low nibble first, then high nibble.
  - The next byte is prefetched into a hold register during the low-nibble phase.
  - crc is updated per byte using the reflected polynomial 32'hEDB88320, LSB first.
  - After byte len_q-1: go to PAD if len_q<60, else to FCS.
- **PAD**: 4'h0 nibbles until the total data byte count reaches 60. Pad bytes are included in the CRC.
- **FCS**: send ~crc, byte 0 (bits 7:0) first, low nibble first, 8 nibbles in total.
- **IFG**: mii_tx_en=0 and mii_txd=0 for IFG_NIB strobes, then pulse done and return to IDLE.

Arithmetic and widths:
- Byte counter is 16 bits; nibble counter is 5 bits.
- buf_addr never exceeds len_q-1; it wraps to 0 on return to IDLE.

Boundary conditions:
- len > MTU: send MTU bytes.
- len=0: send 60 zero pad bytes.
- len=60: no PAD state is entered.
- Reset mid-frame: all outputs go to 0 immediately. mii_tx_en dropping mid-frame is accepted as a truncated frame.

## Timing
Reset values:
- mii_txd=0, mii_tx_en=0, busy=0, done=0, buf_addr=0.

Output timing:
- mii_txd and mii_tx_en are registered and change only on clk edges where nib_stb=1.
- busy rises 1 clk after start is accepted.
- The first preamble nibble appears on the first nib_stb at least 1 clk after start.

Buffer read timing:
- buf_addr for byte k+1 is presented at the latest on the clk after byte k's low nibble is issued.
- buf_data is captured 1 clk later, which is why the 3-clk strobe spacing is required.

Frame and gap timing:
- mii_tx_en stays high for exactly 16 + 2·max(len_q,60) + 8 consecutive strobes.
- done occurs on the clk after the IFG_NIB-th idle strobe.
- busy falls on the same clk as done.

## Structure
Shared package `eth_pkg`:
- state enum;
- constants: PREAMBLE_NIB=16, MIN_FRAME=60, CRC_INIT=32'hFFFFFFFF, CRC_POLY_R=32'hEDB88320.

Sub-module `eth_crc32`:
- combinational next-CRC for one byte: inputs crc_in[31:0], d[7:0]; output crc_out[31:0].
- Instantiated once in `eth_mii_tx`.

## Test plan
- **len=64, buffer bytes i&8'hFF, nib_stb every 4 clk**
  - Required: 15×5, D, then 128 data nibbles 0,0,1,0,…,F,3, then 8 FCS nibbles.
  - The FCS must equal zlib crc32 of bytes 0..63.
  - mii_tx_en must be high for 152 strobes.
- **len=10**
  - Required: 10 data bytes, then 50 zero bytes, then FCS over all 60 bytes.
  - mii_tx_en must be high for 144 strobes.
- **len=0**
  - Required: 60 zero bytes, then FCS = crc32 of 60 zeros.
  - buf_addr must never change from 0.
- **len=2000 with MTU=1536**
  - Required: exactly 1536 bytes sent and buf_addr max 1535.
- **start asserted again mid-DATA, and again 1 clk after done**
  - Required: the first is ignored (the frame is unaltered); the second starts a new frame.
  - The gap between frames must be ≥ 24 strobes.
- **rst_n low during the FCS phase**
  - Required: mii_tx_en and busy are 0 in the same cycle.
  - After release, the block is IDLE and a new start (len=60) transmits a correct frame.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the MII transmit MAC stage.
// Covers the frame FSM state set, the frame constants and the length clamp.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_e;

   localparam int unsigned PREAMBLE_NIB = 16;
   localparam int unsigned MIN_FRAME    = 60;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_POLY_R   = 32'hEDB88320;

   function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] mtu);
      return (len > mtu) ? mtu : len;
   endfunction

endpackage

// File: rtl/eth_mii_tx_if.sv
// Bundles the start/length handshake, the transmit-buffer read port and the MII pins.
// master = controller/buffer side, slave = eth_mii_tx.
interface eth_mii_tx_if #(
   parameter int unsigned ADDR_W = 11
) ();

   logic              start;
   logic [15:0]       len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_data;
   logic              nib_stb;
   logic [3:0]        mii_txd;
   logic              mii_tx_en;

   modport master (
      output start, len, buf_data, nib_stb,
      input  busy, done, buf_addr, mii_txd, mii_tx_en
   );

   modport slave (
      input  start, len, buf_data, nib_stb,
      output busy, done, buf_addr, mii_txd, mii_tx_en
   );

endinterface

// File: rtl/eth_crc32.sv
// Combinational CRC-32 update for one byte.
// Uses the reflected polynomial and processes the byte LSB first.
module eth_crc32
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h000000, d};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/eth_mii_tx.sv
// MII transmit MAC: reads len bytes from the transmit buffer and sends preamble/SFD,
// payload, zero pad to 60 bytes and the FCS, then holds off for the inter-frame gap.
module eth_mii_tx
   import eth_pkg::*;
#(
   parameter int unsigned MTU     = 1536,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned IFG_NIB = 24
) (
   input logic         clk,
   input logic         rst_n,
   eth_mii_tx_if.slave bus
);

   localparam logic [15:0] MTU_W    = 16'(MTU);
   localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
   localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_NIB - 1);
   localparam logic [4:0]  FCS_LAST = 5'd7;
   localparam logic [4:0]  IFG_LAST = 5'(IFG_NIB - 1);

   tx_state_e         state;
   logic [15:0]       len_q;
   logic [15:0]       byte_cnt;
   logic [15:0]       byte_nxt;
   logic [4:0]        nib_cnt;
   logic [31:0]       crc;
   logic [31:0]       crc_next;
   logic [31:0]       fcs;
   logic [7:0]        crc_byte;
   logic [3:0]        fcs_nib;
   logic [7:0]        hold;
   logic [3:0]        hi_q;
   logic [1:0]        rd_pipe;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        txd;
   logic              tx_en;
   logic              busy;
   logic              done;

   always_comb begin
      crc_byte = (state == ST_DATA) ? hold : 8'h00;
      byte_nxt = byte_cnt + 16'd1;
      fcs      = ~crc;
      fcs_nib  = fcs[{nib_cnt[2:0], 2'b00} +: 4];
   end

   eth_crc32 u_crc (
      .crc_in  (crc),
      .d       (crc_byte),
      .crc_out (crc_next)
   );

   // rd_pipe tracks a buffer read in flight: address out, RAM registers, then capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         len_q    <= '0;
         byte_cnt <= '0;
         nib_cnt  <= '0;
         crc      <= CRC_INIT;
         hold     <= '0;
         hi_q     <= '0;
         rd_pipe  <= '0;
         addr     <= '0;
         txd      <= '0;
         tx_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done    <= 1'b0;
         rd_pipe <= {rd_pipe[0], 1'b0};
         if (rd_pipe[1]) hold <= bus.buf_data;

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  len_q    <= clamp_len(bus.len, MTU_W);
                  byte_cnt <= '0;
                  nib_cnt  <= '0;
                  crc      <= CRC_INIT;
                  addr     <= '0;
                  rd_pipe  <= 2'b01;
                  busy     <= 1'b1;
                  state    <= ST_PRE;
               end
            end

            ST_PRE: begin
               if (bus.nib_stb) begin
                  tx_en   <= 1'b1;
                  txd     <= (nib_cnt == PRE_LAST) ? 4'hD : 4'h5;
                  nib_cnt <= nib_cnt + 5'd1;
                  if (nib_cnt == PRE_LAST) begin
                     nib_cnt <= '0;
                     state   <= (len_q == '0) ? ST_PAD : ST_DATA;
                  end
               end
            end

            // Low nibble consumes hold and launches the next byte's read; the high
            // nibble comes from hi_q so hold is free to be refilled meanwhile.
            ST_DATA: begin
               if (bus.nib_stb) begin
                  if (!nib_cnt[0]) begin
                     txd     <= hold[3:0];
                     hi_q    <= hold[7:4];
                     crc     <= crc_next;
                     nib_cnt <= 5'd1;
                     if (byte_nxt < len_q) begin
                        addr    <= addr + ADDR_W'(1);
                        rd_pipe <= 2'b01;
                     end
                  end else begin
                     txd      <= hi_q;
                     nib_cnt  <= '0;
                     byte_cnt <= byte_nxt;
                     if (byte_nxt == len_q) state <= (len_q < MIN_W) ? ST_PAD : ST_FCS;
                  end
               end
            end

            ST_PAD: begin
               if (bus.nib_stb) begin
                  txd <= 4'h0;
                  if (!nib_cnt[0]) begin
                     crc     <= crc_next;
                     nib_cnt <= 5'd1;
                  end else begin
                     nib_cnt  <= '0;
                     byte_cnt <= byte_nxt;
                     if (byte_nxt == MIN_W) state <= ST_FCS;
                  end
               end
            end

            ST_FCS: begin
               if (bus.nib_stb) begin
                  txd     <= fcs_nib;
                  nib_cnt <= nib_cnt + 5'd1;
                  if (nib_cnt == FCS_LAST) begin
                     nib_cnt <= '0;
                     state   <= ST_IFG;
                  end
               end
            end

            ST_IFG: begin
               if (bus.nib_stb) begin
                  tx_en   <= 1'b0;
                  txd     <= 4'h0;
                  nib_cnt <= nib_cnt + 5'd1;
                  if (nib_cnt == IFG_LAST) begin
                     nib_cnt <= '0;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     addr    <= '0;
                     state   <= ST_IDLE;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.buf_addr  = addr;
   assign bus.mii_txd   = txd;
   assign bus.mii_tx_en = tx_en;

endmodule

// File: tb/tb_eth_mii_tx.sv
// Randomized self-checking bench for eth_mii_tx: captured MII nibble streams are
// compared against a frame-level model built from the buffer contents and a table CRC.
module tb_eth_mii_tx;

   localparam int MTU     = 1536;
   localparam int ADDR_W  = 11;
   localparam int IFG_NIB = 24;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eth_mii_tx_if #(.ADDR_W(ADDR_W)) bus ();

   eth_mii_tx #(.MTU(MTU), .ADDR_W(ADDR_W), .IFG_NIB(IFG_NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Registered-read transmit buffer
   logic [7:0] mem [0:2047];
   always @(posedge clk) bus.buf_data <= mem[bus.buf_addr];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Strobe generator and MII/buffer monitor share one negedge process
   int         stb_per     = 4;
   int         stb_cnt     = 0;
   logic [3:0] cap[$];
   int         idle_stb    = 0;
   int         last_gap    = 0;
   int         ifg_at_done = -1;
   int         max_addr    = 0;
   int         unstable    = 0;
   logic       prev_en     = 1'b0;
   logic       prev_busy   = 1'b0;
   logic       prev_rst    = 1'b0;
   logic [3:0] prev_txd    = 4'h0;

   always @(negedge clk) begin
      if (bus.nib_stb) begin
         if (bus.mii_tx_en) begin
            if (!prev_en) begin
               cap.delete();
               last_gap = idle_stb;
            end
            cap.push_back(bus.mii_txd);
            idle_stb = 0;
         end else begin
            idle_stb++;
         end
      end else if (rst_n && prev_rst && (bus.mii_tx_en !== prev_en || bus.mii_txd !== prev_txd)) begin
         unstable++;
      end
      if (bus.done) ifg_at_done = idle_stb;
      if (bus.busy && !prev_busy) max_addr = 0;
      if (bus.busy && int'(bus.buf_addr) > max_addr) max_addr = int'(bus.buf_addr);
      prev_en   = bus.mii_tx_en;
      prev_txd  = bus.mii_txd;
      prev_busy = bus.busy;
      prev_rst  = rst_n;
      stb_cnt++;
      if (stb_cnt >= stb_per) begin
         bus.nib_stb = 1'b1;
         stb_cnt     = 0;
      end else begin
         bus.nib_stb = 1'b0;
      end
   end

   // Reference model
   logic [31:0] crc_tbl [0:255];
   logic [3:0]  exp_q[$];
   logic [31:0] exp_fcs;

   task automatic build_table();
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tbl[i] = c;
      end
   endtask

   function automatic int clamp(input int len);
      return (len > MTU) ? MTU : len;
   endfunction

   task automatic build_exp(input int len);
      int          n, total;
      logic [7:0]  b;
      logic [31:0] c;
      n     = clamp(len);
      total = (n < 60) ? 60 : n;
      exp_q.delete();
      repeat (15) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < total; i++) begin
         b = (i < n) ? mem[i] : 8'h00;
         exp_q.push_back(b[3:0]);
         exp_q.push_back(b[7:4]);
         c = crc_tbl[c[7:0] ^ b] ^ (c >> 8);
      end
      exp_fcs = ~c;
      for (int j = 0; j < 8; j++) exp_q.push_back(exp_fcs[4*j +: 4]);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
   endtask

   task automatic start_frame(input int len);
      bus.len   = 16'(len);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic int frame_budget(input int len);
      int n;
      n = clamp(len);
      if (n < 60) n = 60;
      return (16 + 2*n + 8 + IFG_NIB + 4) * (stb_per + 1) + 50;
   endfunction

   task automatic check_frame(input int len, input string tag);
      int          mism, sz, n;
      logic [31:0] obs;
      build_exp(len);
      sz = cap.size();
      n  = clamp(len);
      check({tag, "_nib_count"}, 32'(sz), 32'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < sz && i < exp_q.size(); i++) if (cap[i] !== exp_q[i]) mism++;
      check({tag, "_nib_mismatches"}, 32'(mism), 32'd0);
      obs = '0;
      if (sz >= 8) for (int k = 0; k < 8; k++) obs |= 32'(cap[sz-8+k]) << (4*k);
      check({tag, "_fcs"}, obs, exp_fcs);
      check({tag, "_max_addr"}, 32'(max_addr), 32'((n == 0) ? 0 : n - 1));
      check({tag, "_ifg"}, 32'(ifg_at_done), 32'(IFG_NIB));
      check({tag, "_addr_wrap"}, 32'(bus.buf_addr), 32'd0);
      check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
      check({tag, "_stable"}, 32'(unstable), 32'd0);
   endtask

   task automatic run_frame(input int len, input string tag);
      bit ok;
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      start_frame(len);
      check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      wait_done(frame_budget(len), ok);
      check({tag, "_done"}, 32'(ok), 32'd1);
      check_frame(len, tag);
      tick();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bit ok;
      bit reached;
      int len;

      build_table();
      bus.start = 1'b0;
      bus.len   = '0;
      fill_random();
      repeat (3) tick();
      check("rst_txd",  32'(bus.mii_txd),   32'd0);
      check("rst_en",   32'(bus.mii_tx_en), 32'd0);
      check("rst_busy", 32'(bus.busy),      32'd0);
      check("rst_done", 32'(bus.done),      32'd0);
      check("rst_addr", 32'(bus.buf_addr),  32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      stb_per = 4;
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
      run_frame(64, "len64");

      fill_random();
      run_frame(10, "len10");
      run_frame(0, "len0");
      run_frame(60, "len60");
      run_frame(2000, "len2000");

      // Start mid-DATA is ignored; start one clock after done begins a new frame
      fill_random();
      start_frame(100);
      reached = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (bus.mii_tx_en && cap.size() >= 56) begin
            reached = 1'b1;
            break;
         end
      end
      check("mid_reach_data", 32'(reached), 32'd1);
      start_frame(5);
      wait_done(frame_budget(100), ok);
      check("mid_done", 32'(ok), 32'd1);
      check_frame(100, "mid");
      tick();
      check("restart_done_low", 32'(bus.done), 32'd0);
      start_frame(30);
      check("restart_busy_rise", 32'(bus.busy), 32'd1);
      wait_done(frame_budget(30), ok);
      check("restart_done", 32'(ok), 32'd1);
      check_frame(30, "restart");
      check("restart_gap_ge_ifg", 32'(last_gap >= IFG_NIB), 32'd1);
      tick();

      // Reset asserted while the FCS is on the wire
      fill_random();
      start_frame(60);
      reached = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (bus.mii_tx_en && cap.size() >= 16 + 120 + 3) begin
            reached = 1'b1;
            break;
         end
      end
      check("rst_fcs_reach", 32'(reached), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_fcs_en",   32'(bus.mii_tx_en), 32'd0);
      check("rst_fcs_busy", 32'(bus.busy),      32'd0);
      check("rst_fcs_txd",  32'(bus.mii_txd),   32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      fill_random();
      run_frame(60, "post_rst");

      for (int f = 0; f < 6; f++) begin
         stb_per = int'($urandom_range(3, 6));
         fill_random();
         len = int'($urandom_range(0, 200));
         run_frame(len, $sformatf("rand%0d_len%0d", f, len));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
